mem_stage: RTL

- MIPS pipeline memory stage; the receiving end of the execute stage's outputs (ALU result, store data, destination register, reg/mem control).
- Performs loads and stores, including byte and halfword forms, against an internal synchronous data RAM.
- Owns the MEM/WB pipeline register.
- Returns the MEM-stage result and destination to the forwarding unit that feeds the execute stage.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_data_ram.sv | 41 ++++
 rtl/mem_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage.
// Holds the access-size encodings, byte-enable patterns, the MEM/WB register
// layout and small helpers for lane enables and alignment checks.
package mem_stage_pkg;

    // Access-size encodings carried on i_mem_size (2'b11 behaves as a word).
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Byte-enable patterns, bit n enables byte lane n (little-endian).
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // MEM/WB pipeline register. The raw load word lives in the RAM's output
    // register; raw_valid masks it to zero after reset or flush.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [1:0]  offset;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [4:0]  write_register;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
        logic        raw_valid;
    } memwb_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            MEM_SIZE_BYTE: be = 4'b0001 << offset;
            MEM_SIZE_HALF: be = offset[1] ? BE_HI_HALF : BE_LO_HALF;
            default:       be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = offset[0];
            default:       mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Single-port synchronous data RAM with four byte-write enables.
// Read-first: a read and write to the same word in one cycle returns the old
// word. The read register only updates when en_i is high, so a stalled
// pipeline keeps its loaded word. No reset logic; contents persist.
// Ports:
//   clk      - clock
//   en_i     - read-register update enable
//   be_i     - byte-lane write enables
//   addr_i   - word address
//   wdata_i  - write data (lanes already replicated by the caller)
//   rdata_o  - registered read data
module data_ram #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage.
// Performs byte/half/word loads and stores against an internal data RAM, owns
// the MEM/WB pipeline register and exposes the MEM-stage result for
// forwarding into execute.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   i_alu_result          - effective address or ALU result
//   i_write_data          - store data
//   i_write_register      - destination register
//   i_reg_write           - register write enable
//   i_mem_read/i_mem_write- load / store
//   i_mem_to_reg          - WB selects memory data
//   i_mem_size            - 00 byte, 01 half, 10/11 word
//   i_mem_unsigned        - zero-extend sub-word loads
//   i_stall, i_flush      - hold / bubble the MEM/WB register
//   o_wb_*                - write-back value, destination, enable
//   o_misaligned          - one-cycle flag for a misaligned access
//   o_fwd_mem_*           - combinational forwarding of the MEM-stage result
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_write_data,
    input  logic [4:0]  i_write_register,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_to_reg,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_wb_write_data,
    output logic [4:0]  o_wb_write_register,
    output logic        o_wb_reg_write,
    output logic        o_misaligned,
    output logic [31:0] o_fwd_mem_value,
    output logic [4:0]  o_fwd_mem_reg,
    output logic        o_fwd_mem_valid
);

    logic [1:0]            offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  access_mis;
    logic                  store_en;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic                  ram_en;
    logic [31:0]           ram_rdata;
    logic [31:0]           raw_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;
    memwb_t                memwb_d, memwb_q;

    // Upper address bits alias onto the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_alu_result[31:ADDR_WIDTH+2];

    assign offset     = i_alu_result[1:0];
    assign word_idx   = i_alu_result[ADDR_WIDTH+1:2];
    // Only real memory accesses can be misaligned; ALU results pass untouched.
    assign access_mis = (i_mem_read | i_mem_write) & is_misaligned(i_mem_size, offset);
    assign store_en   = i_mem_write & ~access_mis & ~i_stall & ~i_flush & reset;
    assign ram_be     = store_en ? byte_enable(i_mem_size, offset) : BE_NONE;

    always_comb begin
        ram_wdata = i_write_data;
        case (i_mem_size)
            MEM_SIZE_BYTE: ram_wdata = {4{i_write_data[7:0]}};
            MEM_SIZE_HALF: ram_wdata = {2{i_write_data[15:0]}};
            default:       ram_wdata = i_write_data;
        endcase
    end

    // The RAM read register is the raw-word field of MEM/WB, so it must hold
    // exactly when the rest of the register holds.
    assign ram_en = ~reset | i_flush | ~i_stall;

    data_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_data_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .be_i   (ram_be),
        .addr_i (word_idx),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        memwb_d = memwb_q;
        if (i_flush) begin
            memwb_d = '0;
        end else if (!i_stall) begin
            memwb_d.alu_result     = i_alu_result;
            memwb_d.offset         = offset;
            memwb_d.size           = i_mem_size;
            memwb_d.is_unsigned    = i_mem_unsigned;
            memwb_d.write_register = i_write_register;
            memwb_d.reg_write      = i_reg_write & ~access_mis;
            memwb_d.mem_to_reg     = i_mem_to_reg;
            memwb_d.misaligned     = access_mis;
            memwb_d.raw_valid      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign raw_word = memwb_q.raw_valid ? ram_rdata : 32'h0;

    always_comb begin
        ld_byte = raw_word[7:0];
        case (memwb_q.offset)
            2'd0:    ld_byte = raw_word[7:0];
            2'd1:    ld_byte = raw_word[15:8];
            2'd2:    ld_byte = raw_word[23:16];
            default: ld_byte = raw_word[31:24];
        endcase
        ld_half = memwb_q.offset[1] ? raw_word[31:16] : raw_word[15:0];
        case (memwb_q.size)
            MEM_SIZE_BYTE: ld_data = memwb_q.is_unsigned ? {24'h0, ld_byte}
                                                         : {{24{ld_byte[7]}}, ld_byte};
            MEM_SIZE_HALF: ld_data = memwb_q.is_unsigned ? {16'h0, ld_half}
                                                         : {{16{ld_half[15]}}, ld_half};
            default:       ld_data = raw_word;
        endcase
    end

    assign o_wb_write_data     = memwb_q.mem_to_reg ? ld_data : memwb_q.alu_result;
    assign o_wb_write_register = memwb_q.write_register;
    assign o_wb_reg_write      = memwb_q.reg_write;
    assign o_misaligned        = memwb_q.misaligned;

    // A load's data is not available until WB, so it cannot forward from MEM.
    assign o_fwd_mem_value = i_alu_result;
    assign o_fwd_mem_reg   = i_write_register;
    assign o_fwd_mem_valid = i_reg_write & ~i_mem_read;

endmodule
